// File: rtl/manchester_pkg.sv
// Shared types and line-coding helper for the Manchester transmitter.
package manchester_pkg;

    localparam bit IEEE   = 1'b1;
    localparam bit THOMAS = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } state_t;

    // Line level for one half of bit b; IEEE sends ~b then b, Thomas the reverse.
    function automatic logic man_half(input bit b, input bit second_half, input bit ieee_pol);
        return logic'(b ^ ieee_pol ^ second_half);
    endfunction

endpackage

// File: rtl/manchester_half_timer.sv
// Half-bit and bit strobes; counters sit at zero whenever run is low.
module manchester_half_timer #(
    parameter int HALF_BIT_CLKS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic half_tick,
    output logic bit_tick
);

    localparam int CW = $clog2(HALF_BIT_CLKS) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d;

    assign half_tick = run && (cnt_q == CW'(HALF_BIT_CLKS - 1));
    assign bit_tick  = half_tick && half_q;

    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        if (!run) begin
            cnt_d  = '0;
            half_d = 1'b0;
        end else if (half_tick) begin
            cnt_d  = '0;
            half_d = ~half_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/manchester_tx.sv
// Framed Manchester serialiser: optional alternating preamble, then DATA_W payload bits.
module manchester_tx
    import manchester_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int HALF_BIT_CLKS = 1,
    parameter int PREAMBLE_BITS = 0,
    parameter int IEEE_POL      = 1,
    parameter int MSB_FIRST     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              tx_out,
    output logic              tx_en,
    output logic              busy,
    output logic              done
);

    localparam int MAXB = (DATA_W > PREAMBLE_BITS) ? DATA_W : PREAMBLE_BITS;
    localparam int BW   = $clog2(MAXB + 1);
    localparam bit POL  = (IEEE_POL != 0);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_nx, s_data_ord;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_en_q, tx_en_d;
    logic              done_q, done_d;
    logic              half_tick, bit_tick;
    logic              accept, last_pre, last_data, cur_bit;

    manchester_half_timer #(.HALF_BIT_CLKS(HALF_BIT_CLKS)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (state_q != IDLE),
        .half_tick (half_tick),
        .bit_tick  (bit_tick)
    );

    // Words are stored in transmit order so the shifter always emits from the top.
    always_comb begin
        s_data_ord = '0;
        for (int i = 0; i < DATA_W; i++) begin
            s_data_ord[i] = (MSB_FIRST != 0) ? s_data[i] : s_data[DATA_W-1-i];
        end
    end

    assign accept    = s_valid && (state_q == IDLE);
    assign last_pre  = (bit_cnt_q == BW'(PREAMBLE_BITS - 1));
    assign last_data = (bit_cnt_q == BW'(DATA_W - 1));
    assign shift_nx  = shift_q << 1;
    // Preamble bit k is 1 for even k.
    assign cur_bit   = (state_q == PREAMBLE) ? ~bit_cnt_q[0] : shift_q[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_out_q  <= 1'b0;
            tx_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_out_q  <= tx_out_d;
            tx_en_q   <= tx_en_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = (PREAMBLE_BITS > 0) ? PREAMBLE : DATA;
            PREAMBLE: if (bit_tick && last_pre) state_d = DATA;
            DATA:     if (bit_tick && last_data) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_out_d  = tx_out_q;
        tx_en_d   = tx_en_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = s_data_ord;
                    bit_cnt_d = '0;
                    tx_en_d   = 1'b1;
                    tx_out_d  = man_half((PREAMBLE_BITS > 0) ? 1'b1 : s_data_ord[DATA_W-1], 1'b0, POL);
                end
            end
            PREAMBLE: begin
                if (bit_tick) begin
                    if (last_pre) begin
                        bit_cnt_d = '0;
                        tx_out_d  = man_half(shift_q[DATA_W-1], 1'b0, POL);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_out_d  = man_half(bit_cnt_q[0], 1'b0, POL);
                    end
                end else if (half_tick) begin
                    tx_out_d = man_half(cur_bit, 1'b1, POL);
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_nx;
                    if (last_data) begin
                        bit_cnt_d = '0;
                        tx_out_d  = 1'b0;
                        tx_en_d   = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_out_d  = man_half(shift_nx[DATA_W-1], 1'b0, POL);
                    end
                end else if (half_tick) begin
                    tx_out_d = man_half(cur_bit, 1'b1, POL);
                end
            end
            default: begin
                tx_out_d = 1'b0;
                tx_en_d  = 1'b0;
            end
        endcase
    end

    assign s_ready = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign tx_out  = tx_out_q;
    assign tx_en   = tx_en_q;
    assign done    = done_q;

endmodule

// File: tb/tb_manchester_tx.sv
// Directed bench for manchester_tx over three parameter sets, with a per-cycle line-level scoreboard.
module tb_manchester_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid_v [3];
    logic [7:0] s_data_v  [3];
    logic       s_ready_v [3];
    logic       tx_out_v  [3];
    logic       tx_en_v   [3];
    logic       busy_v    [3];
    logic       done_v    [3];

    // Instance configurations: 0 default IEEE/MSB, 1 Thomas/LSB, 2 slow with preamble.
    int cfg_h   [3] = '{1, 1, 4};
    int cfg_p   [3] = '{0, 0, 4};
    int cfg_pol [3] = '{1, 0, 1};
    int cfg_msb [3] = '{1, 0, 1};

    logic [0:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    manchester_tx #(.DATA_W(8), .HALF_BIT_CLKS(1), .PREAMBLE_BITS(0), .IEEE_POL(1), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]), .s_data(s_data_v[0]),
        .tx_out(tx_out_v[0]), .tx_en(tx_en_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    manchester_tx #(.DATA_W(8), .HALF_BIT_CLKS(1), .PREAMBLE_BITS(0), .IEEE_POL(0), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]), .s_data(s_data_v[1]),
        .tx_out(tx_out_v[1]), .tx_en(tx_en_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    manchester_tx #(.DATA_W(8), .HALF_BIT_CLKS(4), .PREAMBLE_BITS(4), .IEEE_POL(1), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst), .s_valid(s_valid_v[2]), .s_ready(s_ready_v[2]), .s_data(s_data_v[2]),
        .tx_out(tx_out_v[2]), .tx_en(tx_en_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bit(input logic b, input int pol, input int h);
        logic first;
        first = (pol != 0) ? ~b : b;
        for (int j = 0; j < h; j++) exp_q.push_back(first);
        for (int j = 0; j < h; j++) exp_q.push_back(~first);
    endtask

    task automatic push_expected(input int idx, input logic [7:0] word);
        for (int k = 0; k < cfg_p[idx]; k++) push_bit((k % 2) == 0, cfg_pol[idx], cfg_h[idx]);
        for (int i = 0; i < 8; i++)
            push_bit((cfg_msb[idx] != 0) ? word[7-i] : word[i], cfg_pol[idx], cfg_h[idx]);
    endtask

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic send(input int idx, input logic [7:0] word, input bit hold);
        int n;
        s_data_v[idx]  = word;
        s_valid_v[idx] = 1'b1;
        n = 0;
        while (!s_ready_v[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_handshake", s_ready_v[idx], 1);
        push_expected(idx, word);
        @(posedge clk);
        @(negedge clk);
        if (!hold) s_valid_v[idx] = 1'b0;
    endtask

    task automatic play_frame(input int idx, input bit scramble);
        logic [0:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tx_out_level", tx_out_v[idx], e);
            check("tx_en_in_frame", tx_en_v[idx], 1);
            check("busy_in_frame", busy_v[idx], 1);
            check("ready_low_in_frame", s_ready_v[idx], 0);
            check("no_done_in_frame", done_v[idx], 0);
            if (scramble) s_data_v[idx] = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        check("done_at_end", done_v[idx], 1);
        check("tx_en_at_end", tx_en_v[idx], 0);
        check("tx_out_at_end", tx_out_v[idx], 0);
        check("busy_at_end", busy_v[idx], 0);
        check("ready_at_end", s_ready_v[idx], 1);
    endtask

    initial begin
        logic [0:0] e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid_v[i] = 1'b0;
            s_data_v[i]  = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", s_ready_v[i], 1);
            check("reset_tx_out", tx_out_v[i], 0);
            check("reset_tx_en", tx_en_v[i], 0);
            check("reset_busy", busy_v[i], 0);
            check("reset_done", done_v[i], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // IEEE, MSB first, 0xA5 and a few random words
        send(0, 8'hA5, 1'b0);
        play_frame(0, 1'b0);
        @(negedge clk);
        check("done_one_cycle", done_v[0], 0);
        for (int r = 0; r < 3; r++) begin
            send(0, 8'($urandom_range(0, 255)), 1'b0);
            play_frame(0, 1'b0);
            @(negedge clk);
        end

        // Thomas, LSB first
        send(1, 8'hA5, 1'b0);
        play_frame(1, 1'b0);
        @(negedge clk);
        send(1, 8'h1E, 1'b0);
        play_frame(1, 1'b0);
        @(negedge clk);

        // Preamble with 4-cycle half-bits
        send(2, 8'h00, 1'b0);
        play_frame(2, 1'b0);
        @(negedge clk);
        send(2, 8'hB1, 1'b0);
        play_frame(2, 1'b0);
        @(negedge clk);

        // Back-to-back with s_valid held high
        send(0, 8'h3C, 1'b1);
        s_data_v[0] = 8'hC3;
        play_frame(0, 1'b0);
        push_expected(0, 8'hC3);
        @(posedge clk);
        @(negedge clk);
        s_valid_v[0] = 1'b0;
        play_frame(0, 1'b0);
        @(negedge clk);
        check("b2b_done_one_cycle", done_v[0], 0);
        check("b2b_idle_after", tx_en_v[0], 0);

        // Reset mid-frame at cycle 5
        send(0, 8'h5A, 1'b0);
        for (int c = 0; c < 5; c++) begin
            e = exp_q.pop_front();
            check("pre_abort_level", tx_out_v[0], e);
            if (c < 4) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_out", tx_out_v[0], 0);
        check("abort_tx_en", tx_en_v[0], 0);
        check("abort_busy", busy_v[0], 0);
        check("abort_ready", s_ready_v[0], 1);
        check("abort_no_done", done_v[0], 0);
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_quiet_done", done_v[0], 0);
            check("abort_quiet_tx_en", tx_en_v[0], 0);
        end
        send(0, 8'hE7, 1'b0);
        play_frame(0, 1'b0);
        @(negedge clk);

        // s_data scrambled while busy must not disturb the captured word
        send(0, 8'h96, 1'b0);
        play_frame(0, 1'b1);
        @(negedge clk);
        send(2, 8'h4D, 1'b0);
        play_frame(2, 1'b1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
